// File: rtl/apb_master_bridge_pkg.sv
// Shared APB bus definitions used by the bridge and the periphery subsystem.
package apb_master_bridge_pkg;

  localparam int unsigned APB_AW_DEF = 32;
  localparam int unsigned APB_DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

  // Timeout counter width; at least one bit even when the timeout is disabled.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB4 master bridge: one transfer in flight,
// single response slot, stalled transfers terminated by a timeout error.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned APB_AW         = APB_AW_DEF,
  parameter int unsigned APB_DW         = APB_DW_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [APB_AW-1:0]   req_addr,
  input  logic                req_write,
  input  logic [APB_DW-1:0]   req_wdata,
  input  logic [APB_DW/8-1:0] req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [APB_DW-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [APB_AW-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [APB_DW-1:0]   pwdata,
  output logic [APB_DW/8-1:0] pstrb,
  input  logic                pready,
  input  logic [APB_DW-1:0]   prdata
);

  localparam int unsigned     CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W:0]  TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  apb_mst_state_e   state;
  logic [CNT_W-1:0] wait_cnt;
  logic             to_hit;

  // Held low during reset so nothing is offered while the bridge is being cleared.
  assign req_ready = !prst && (state == IDLE) && !rsp_valid;

  // True in the ACCESS cycle whose wait would bring the counter to the limit.
  assign to_hit = (TIMEOUT_CYCLES != 0) &&
                  (({1'b0, wait_cnt} + (CNT_W + 1)'(1)) >= TO_LIMIT);

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_write ? req_wdata : '0;
            pstrb  <= req_write ? req_strb : '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle.
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (to_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (!(&wait_cnt)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with a 4-cycle timeout.
module tb_apb_master_bridge;

  logic        pclk;
  logic        prst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .APB_AW(32),
    .APB_DW(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb(req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .pstrb(pstrb),
    .pready(pready),
    .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    chk({tag, "_psel"},      32'(psel), 32'd0);
    chk({tag, "_penable"},   32'(penable), 32'd0);
    chk({tag, "_paddr"},     paddr, 32'd0);
    chk({tag, "_pwrite"},    32'(pwrite), 32'd0);
    chk({tag, "_pwdata"},    pwdata, 32'd0);
    chk({tag, "_pstrb"},     32'(pstrb), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;

    prst      = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    prdata    = '0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    prst = 1'b0;
    #1;
    chk("reset_req_ready_after", 32'(req_ready), 32'd1);

    // Zero-wait write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010;
    req_wdata = 32'hDEAD_BEEF; req_strb = 4'hF; pready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t1_c1_psel", 32'(psel), 32'd1);
    chk("t1_c1_penable", 32'(penable), 32'd0);
    chk("t1_c1_paddr", paddr, 32'h0000_0010);
    chk("t1_c1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("t1_c1_pstrb", 32'(pstrb), 32'hF);
    chk("t1_c1_pwrite", 32'(pwrite), 32'd1);
    chk("t1_c1_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("t1_c2_psel", 32'(psel), 32'd1);
    chk("t1_c2_penable", 32'(penable), 32'd1);
    chk("t1_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_c3_rsp_err", 32'(rsp_err), 32'd0);
    chk("t1_c3_rsp_rdata", rsp_rdata, 32'd0);
    chk("t1_c3_psel", 32'(psel), 32'd0);
    chk("t1_c3_penable", 32'(penable), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_c4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_c4_req_ready", 32'(req_ready), 32'd1);

    // Read with 3 wait states
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0014;
    req_wdata = 32'h5555_5555; req_strb = 4'hF; pready = 1'b0; prdata = 32'd0;
    step();
    req_valid = 1'b0;
    chk("t2_c1_psel", 32'(psel), 32'd1);
    chk("t2_c1_pstrb", 32'(pstrb), 32'd0);
    chk("t2_c1_pwdata", pwdata, 32'd0);
    chk("t2_c1_pwrite", 32'(pwrite), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_wait_penable", 32'(penable), 32'd1);
      chk("t2_wait_paddr", paddr, 32'h0000_0014);
      chk("t2_wait_pstrb", 32'(pstrb), 32'd0);
      chk("t2_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    pready = 1'b1; prdata = 32'h1234_5678;
    chk("t2_c5_penable", 32'(penable), 32'd1);
    chk("t2_c5_paddr", paddr, 32'h0000_0014);
    step();
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    chk("t2_c6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_c6_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("t2_c6_rsp_err", 32'(rsp_err), 32'd0);
    chk("t2_c6_psel", 32'(psel), 32'd0);

    // Response backpressure with a pending request
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020;
    req_wdata = 32'hA5A5_A5A5; req_strb = 4'h3; pready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_psel", 32'(psel), 32'd0);
      step();
    end
    chk("t4_still_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_cleared_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_cleared_req_ready", 32'(req_ready), 32'd1);
    chk("t4_cleared_psel", 32'(psel), 32'd0);
    step();
    req_valid = 1'b0;
    chk("t4_next_psel", 32'(psel), 32'd1);
    chk("t4_next_paddr", paddr, 32'h0000_0020);
    chk("t4_next_pstrb", 32'(pstrb), 32'h3);
    chk("t4_next_pwdata", pwdata, 32'hA5A5_A5A5);
    step();
    step();
    chk("t4_next_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_next_rsp_err", 32'(rsp_err), 32'd0);
    chk("t4_next_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Timeout after 4 ACCESS cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0030;
    req_strb = 4'h0; pready = 1'b0; prdata = 32'hFFFF_0000;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_access_psel", 32'(psel), 32'd1);
      chk("t3_access_penable", 32'(penable), 32'd1);
      chk("t3_access_rsp_valid", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("t3_c5_psel", 32'(psel), 32'd1);
    chk("t3_c5_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("t3_c6_psel", 32'(psel), 32'd0);
    chk("t3_c6_penable", 32'(penable), 32'd0);
    chk("t3_c6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_c6_rsp_err", 32'(rsp_err), 32'd1);
    chk("t3_c6_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_c7_rsp_valid", 32'(rsp_valid), 32'd0);

    // Request after timeout completes normally
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0034;
    pready = 1'b1; prdata = 32'hCAFE_0001;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("t3_after_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_after_rsp_err", 32'(rsp_err), 32'd0);
    chk("t3_after_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // pready in the same ACCESS cycle the timeout limit is reached
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0038;
    pready = 1'b0; prdata = 32'h0BAD_F00D;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    step();
    pready = 1'b1;
    step();
    pready = 1'b0;
    chk("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tie_rsp_err", 32'(rsp_err), 32'd0);
    chk("tie_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset during ACCESS
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040;
    req_wdata = 32'h1111_2222; req_strb = 4'hF; pready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("t5_in_access", 32'(penable), 32'd1);
    prst = 1'b1;
    step();
    chk_all_zero("t5_reset");
    prst = 1'b0;
    pready = 1'b1;
    #1;
    chk("t5_idle_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_no_psel", 32'(psel), 32'd0);
    end

    // Back-to-back zero-wait writes
    rsp_ready = 1'b1;
    pready    = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_strb  = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_addr  = 32'h0000_0100 + 32'(4 * k);
      req_addr  = exp_addr;
      req_wdata = 32'hC0DE_0000 + 32'(k);
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      step();
      chk("t6_c1_paddr", paddr, exp_addr);
      chk("t6_c1_pwdata", pwdata, 32'hC0DE_0000 + 32'(k));
      step();
      step();
      chk("t6_c3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t6_c3_rsp_err", 32'(rsp_err), 32'd0);
      chk("t6_c3_paddr", paddr, exp_addr);
      step();
    end
    req_valid = 1'b0;
    chk("t6_end_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_end_req_ready", 32'(req_ready), 32'd1);
    step();
    chk("t6_end_psel", 32'(psel), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
